// File: rtl/bar_switch_tracker_if.sv
// rtl/bar_switch_tracker_if.sv - switch bar in, tracked count and strobes out
interface bar_switch_tracker_if;
    logic [14:0] sw;
    logic        step_en;
    logic [3:0]  target;
    logic        target_vld;
    logic        bar_err;
    logic [3:0]  cnt;
    logic        dir;
    logic        step;
    logic        at_target;

    modport master (
        output sw,
        output step_en,
        input  target,
        input  target_vld,
        input  bar_err,
        input  cnt,
        input  dir,
        input  step,
        input  at_target
    );

    modport slave (
        input  sw,
        input  step_en,
        output target,
        output target_vld,
        output bar_err,
        output cnt,
        output dir,
        output step,
        output at_target
    );
endinterface

// File: rtl/bar_switch_tracker.sv
// rtl/bar_switch_tracker.sv - debounced thermometer switch bar driving a stepped up/down tracked count
module bar_switch_tracker #(
    parameter int DB_W   = 20,
    parameter int STEP_W = 25
) (
    input  logic                  clk,
    input  logic                  clr,
    bar_switch_tracker_if.slave   bus
);

    localparam logic [DB_W-1:0] DB_LAST = {{(DB_W-1){1'b1}}, 1'b0};

    logic [14:0]       sw_s1;
    logic [14:0]       sw_s2;
    logic [14:0]       cand;
    logic [14:0]       stable;
    logic [DB_W-1:0]   db_cnt;
    logic              stable_upd;

    logic [STEP_W-1:0] tick_cnt;
    logic              tick;

    logic [3:0]        target_r;
    logic              vld_r;
    logic              err_r;
    logic [3:0]        cnt_r;
    logic              dir_r;
    logic              step_r;
    logic              at_r;

    logic [15:0]       bar_ext;
    logic [15:0]       bar_plus1;
    logic              bar_valid;
    logic [3:0]        bar_level;

    always_ff @(posedge clk) begin
        if (clr) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= bus.sw;
            sw_s2 <= sw_s1;
        end
    end

    // The counter tracks how long cand has matched; stable moves exactly once
    // per settled change, on the edge the run reaches the full window.
    always_ff @(posedge clk) begin
        if (clr) begin
            cand       <= '0;
            db_cnt     <= '0;
            stable     <= '0;
            stable_upd <= 1'b0;
        end else begin
            stable_upd <= 1'b0;
            if (sw_s2 != cand) begin
                cand   <= sw_s2;
                db_cnt <= '0;
            end else begin
                if (db_cnt != '1) begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
                if ((db_cnt == DB_LAST) && (cand != stable)) begin
                    stable     <= cand;
                    stable_upd <= 1'b1;
                end
            end
        end
    end

    // A thermometer code 2^k-1 has no bit in common with its successor.
    always_comb begin
        bar_ext   = {1'b0, stable};
        bar_plus1 = bar_ext + 16'd1;
        bar_valid = ((bar_ext & bar_plus1) == 16'd0);
        bar_level = 4'($countones(stable));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            target_r <= '0;
            vld_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            vld_r <= 1'b0;
            if (stable_upd) begin
                if (bar_valid) begin
                    target_r <= bar_level;
                    vld_r    <= 1'b1;
                    err_r    <= 1'b0;
                end else begin
                    err_r    <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + STEP_W'(1);
        end
    end

    assign tick = &tick_cnt;

    // Tracking reads the registered target, so a target landing on a tick
    // edge is only seen by the following tick.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r  <= '0;
            dir_r  <= 1'b0;
            step_r <= 1'b0;
            at_r   <= 1'b0;
        end else begin
            step_r <= 1'b0;
            at_r   <= (cnt_r == target_r);
            if (tick && bus.step_en) begin
                if (cnt_r < target_r) begin
                    cnt_r  <= cnt_r + 4'd1;
                    dir_r  <= 1'b1;
                    step_r <= 1'b1;
                end else if (cnt_r > target_r) begin
                    cnt_r  <= cnt_r - 4'd1;
                    dir_r  <= 1'b0;
                    step_r <= 1'b1;
                end
            end
        end
    end

    assign bus.target     = target_r;
    assign bus.target_vld = vld_r;
    assign bus.bar_err    = err_r;
    assign bus.cnt        = cnt_r;
    assign bus.dir        = dir_r;
    assign bus.step       = step_r;
    assign bus.at_target  = at_r;

endmodule

// File: tb/tb_bar_switch_tracker.sv
// tb/tb_bar_switch_tracker.sv - directed and random checks of bar_switch_tracker against a cycle reference model
module tb_bar_switch_tracker;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    bar_switch_tracker_if bus ();

    bar_switch_tracker #(.DB_W(2), .STEP_W(3)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int checks;
    int errors;
    int steps_seen;
    int vld_seen;

    logic [14:0] m_d1, m_d2, m_last, m_stable;
    int          m_run;
    bit          m_upd;
    int          m_k;
    logic [3:0]  m_tgt, m_cnt;
    logic        m_dir, m_step, m_vld, m_err, m_at;

    int lat, n, cyc, prev, gap, hold, r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_thermo(input logic [14:0] v);
        for (int k = 0; k <= 15; k++) begin
            if ({1'b0, v} == ((16'd1 << k) - 16'd1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference: switch bar accepted after 4 identical synchronised samples,
    // encoded next cycle, count moves one step every 8th cycle after reset.
    task automatic model_step();
        bit m_tick;
        if (clr) begin
            m_d1 = '0; m_d2 = '0; m_last = '0; m_stable = '0;
            m_run = 1; m_upd = 0; m_k = 0;
            m_tgt = '0; m_cnt = '0;
            m_dir = 0; m_step = 0; m_vld = 0; m_err = 0; m_at = 0;
        end else begin
            m_tick = ((m_k % 8) == 7);
            m_k++;
            m_at = (m_cnt == m_tgt);
            m_step = 0;
            if (m_tick && bus.step_en) begin
                if (m_cnt < m_tgt) begin
                    m_cnt++; m_dir = 1; m_step = 1;
                end else if (m_cnt > m_tgt) begin
                    m_cnt--; m_dir = 0; m_step = 1;
                end
            end
            m_vld = 0;
            if (m_upd) begin
                if (is_thermo(m_stable)) begin
                    m_tgt = 4'($countones(m_stable));
                    m_err = 0;
                    m_vld = 1;
                end else begin
                    m_err = 1;
                end
            end
            m_upd = 0;
            if (m_d2 == m_last) begin
                m_run++;
            end else begin
                m_run = 1;
                m_last = m_d2;
            end
            if (m_run == 4 && m_last != m_stable) begin
                m_stable = m_last;
                m_upd = 1;
            end
            m_d2 = m_d1;
            m_d1 = bus.sw;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("target",     bus.target,     m_tgt);
        check("target_vld", bus.target_vld, m_vld);
        check("bar_err",    bus.bar_err,    m_err);
        check("cnt",        bus.cnt,        m_cnt);
        check("dir",        bus.dir,        m_dir);
        check("step",       bus.step,       m_step);
        check("at_target",  bus.at_target,  m_at);
        if (bus.step === 1'b1) steps_seen++;
        if (bus.target_vld === 1'b1) vld_seen++;
    endtask

    task automatic wait_cnt(input logic [3:0] v, input int bound, input string tag);
        int k;
        k = 0;
        while (bus.cnt !== v && k < bound) begin
            cycle();
            k++;
        end
        check(tag, bus.cnt, v);
    endtask

    task automatic wait_vld(input int bound, input string tag);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (bus.target_vld !== 1'b1 && k < bound);
        check(tag, bus.target_vld, 1);
    endtask

    task automatic wait_step(input int bound, input string tag);
        int k;
        k = 0;
        while (bus.step !== 1'b1 && k < bound) begin
            cycle();
            k++;
        end
        check(tag, bus.step, 1);
    endtask

    initial begin
        checks = 0; errors = 0; steps_seen = 0; vld_seen = 0;
        clr = 1'b1;
        bus.sw = 15'h7FFF;
        bus.step_en = 1'b1;

        cycle();
        cycle();
        check("rst_cnt", bus.cnt, 0);
        check("rst_target", bus.target, 0);
        check("rst_at_target", bus.at_target, 0);
        clr = 1'b0;
        cycle();
        check("rel_at_target", bus.at_target, 1);
        check("rel_no_vld", bus.target_vld, 0);

        bus.sw = 15'h00FF;
        lat = 0;
        do begin
            cycle();
            lat++;
        end while (bus.target_vld !== 1'b1 && lat < 30);
        check("up_latency", lat, 7);
        check("up_target", bus.target, 8);

        steps_seen = 0; cyc = 0; prev = -1; gap = 0;
        while (bus.cnt !== 4'd8 && cyc < 200) begin
            cycle();
            cyc++;
            if (bus.step === 1'b1) begin
                if (prev >= 0 && gap == 0) gap = cyc - prev;
                prev = cyc;
            end
        end
        check("up_cnt8", bus.cnt, 8);
        check("up_step_gap", gap, 8);
        check("up_steps", steps_seen, 8);
        check("up_dir", bus.dir, 1);
        check("up_at_lag", bus.at_target, 0);
        cycle();
        check("up_at", bus.at_target, 1);

        bus.sw = 15'h0007;
        wait_vld(30, "down_vld");
        check("down_target", bus.target, 3);
        wait_cnt(4'd6, 100, "down_cnt6");
        check("down_dir", bus.dir, 0);
        bus.sw = 15'h07FF;
        cycle();
        wait_step(20, "rev_step");
        check("rev_dir", bus.dir, 1);
        check("rev_cnt", bus.cnt, 7);
        wait_cnt(4'd11, 200, "rev_cnt11");
        check("rev_target", bus.target, 11);

        repeat (10) cycle();
        vld_seen = 0;
        bus.sw = 15'h0001;
        cycle();
        cycle();
        bus.sw = 15'h07FF;
        repeat (20) cycle();
        check("glitch_vld", vld_seen, 0);
        check("glitch_target", bus.target, 11);
        check("glitch_err", bus.bar_err, 0);

        bus.sw = 15'h0005;
        repeat (20) cycle();
        check("bubble_err", bus.bar_err, 1);
        check("bubble_target", bus.target, 11);
        check("bubble_vld", vld_seen, 0);
        bus.sw = 15'h7FFF;
        wait_vld(30, "full_vld");
        check("full_err", bus.bar_err, 0);
        check("full_target", bus.target, 15);
        wait_cnt(4'd15, 200, "full_cnt15");
        steps_seen = 0;
        repeat (30) cycle();
        check("nowrap_cnt", bus.cnt, 15);
        check("nowrap_steps", steps_seen, 0);

        bus.step_en = 1'b0;
        bus.sw = 15'h0000;
        wait_vld(30, "freeze_vld");
        check("freeze_target", bus.target, 0);
        steps_seen = 0;
        repeat (32) cycle();
        check("freeze_cnt", bus.cnt, 15);
        check("freeze_steps", steps_seen, 0);
        bus.step_en = 1'b1;
        n = 0;
        while (bus.step !== 1'b1 && n < 8) begin
            cycle();
            n++;
        end
        check("resume_step", bus.step, 1);
        check("resume_cnt", bus.cnt, 14);
        check("resume_dir", bus.dir, 0);

        repeat (60) begin
            r = $urandom_range(0, 3);
            if (r == 0) bus.sw = 15'($urandom);
            else        bus.sw = 15'h7FFF >> $urandom_range(0, 15);
            bus.step_en = ($urandom_range(0, 4) != 0);
            clr = ($urandom_range(0, 29) == 0);
            hold = $urandom_range(1, 14);
            cycle();
            clr = 1'b0;
            repeat (hold) cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
